// File: rtl/life_pkg.sv
// Shared constants, FSM encodings and stop-reason codes for the life run sequencer.
package life_pkg;
  localparam int unsigned GRID  = 16;
  localparam int unsigned CELLS = GRID * GRID;
  localparam int unsigned POP_W = 9;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    RUN    = ST_RUN,
    SETTLE = ST_SETTLE,
    DONE   = ST_DONE
  } state_t;

  localparam logic [1:0] STOP_MAXGEN  = 2'd0;
  localparam logic [1:0] STOP_EXTINCT = 2'd1;
  localparam logic [1:0] STOP_STILL   = 2'd2;
  localparam logic [1:0] STOP_PERIOD2 = 2'd3;
endpackage

// File: rtl/life_popcount.sv
// Combinational population count of the 256-cell grid: per-row sums, then a sum of rows.
module life_popcount
  import life_pkg::*;
(
  input  logic [CELLS-1:0] bits,
  output logic [POP_W-1:0] count
);

  logic [4:0] row_sum [GRID];

  always_comb begin
    for (int unsigned r = 0; r < GRID; r++) begin
      row_sum[r] = '0;
      for (int unsigned c = 0; c < GRID; c++) begin
        row_sum[r] = row_sum[r] + 5'(bits[r*GRID + c]);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned r = 0; r < GRID; r++) begin
      count = count + POP_W'(row_sum[r]);
    end
  end

endmodule

// File: rtl/life_run_ctrl.sv
// Run sequencer for the 16x16 life engine: load, run, early stop, report.
// Optional period-2 stop detection enabled by defining LIFE_PERIOD2_DETECT_EN.
module life_run_ctrl
  import life_pkg::*;
#(
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CELLS-1:0] pattern,
  input  logic [GEN_W-1:0] max_gen,
  input  logic             stop_on_still,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stop_reason,
  output logic [GEN_W-1:0] gen_count,
  output logic [POP_W-1:0] pop_count,
  output logic             eng_load,
  output logic [CELLS-1:0] eng_data,
  input  logic [CELLS-1:0] eng_q
);

  state_t           state, state_n;
  logic [CELLS-1:0] pattern_reg;
  logic [GEN_W-1:0] max_gen_reg;
  logic             still_reg;
  logic [CELLS-1:0] prev_q;
  logic             prev_valid;
`ifdef LIFE_PERIOD2_DETECT_EN
  logic [CELLS-1:0] prev2_q;
  logic             prev2_valid;
`endif

  logic [GEN_W-1:0] gen_n;
  logic [1:0]       reason_n;
  logic             capture, advance;
  logic [POP_W-1:0] pop_w;

  life_popcount u_popcount (
    .bits  (eng_q),
    .count (pop_w)
  );

  // The engine holds by reloading its own state; it only free-runs in RUN.
  assign eng_load = (state != RUN);
  assign eng_data = (state == LOAD) ? pattern_reg : eng_q;

  always_comb begin
    state_n  = state;
    gen_n    = gen_count;
    reason_n = stop_reason;
    capture  = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_n = LOAD;
          capture = 1'b1;
          gen_n   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = IDLE;
        end else if (max_gen_reg == '0) begin
          state_n  = SETTLE;
          reason_n = STOP_MAXGEN;
        end else begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (eng_q == '0) begin
          state_n  = SETTLE;
          reason_n = STOP_EXTINCT;
        end else if (still_reg && prev_valid && (eng_q == prev_q)) begin
          state_n  = SETTLE;
          reason_n = STOP_STILL;
`ifdef LIFE_PERIOD2_DETECT_EN
        end else if (still_reg && prev2_valid && (eng_q == prev2_q)) begin
          state_n  = SETTLE;
          reason_n = STOP_PERIOD2;
`endif
        end else if ((gen_count + GEN_W'(1)) == max_gen_reg) begin
          state_n  = SETTLE;
          reason_n = STOP_MAXGEN;
          gen_n    = max_gen_reg;
        end else begin
          gen_n   = gen_count + GEN_W'(1);
          advance = 1'b1;
        end
      end
      SETTLE: begin
        state_n = abort ? IDLE : DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      stop_reason <= STOP_MAXGEN;
      gen_count   <= '0;
      pop_count   <= '0;
      pattern_reg <= '0;
      max_gen_reg <= '0;
      still_reg   <= 1'b0;
      prev_q      <= '0;
      prev_valid  <= 1'b0;
`ifdef LIFE_PERIOD2_DETECT_EN
      prev2_q     <= '0;
      prev2_valid <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      gen_count   <= gen_n;
      stop_reason <= reason_n;
      busy        <= (state_n == LOAD) || (state_n == RUN) || (state_n == SETTLE);
      done        <= (state == SETTLE) && (state_n == DONE);
      if (state == SETTLE) begin
        pop_count <= pop_w;
      end
      if (capture) begin
        pattern_reg <= pattern;
        max_gen_reg <= max_gen;
        still_reg   <= stop_on_still;
        prev_valid  <= 1'b0;
`ifdef LIFE_PERIOD2_DETECT_EN
        prev2_valid <= 1'b0;
`endif
      end
      if (advance) begin
        prev_q      <= eng_q;
        prev_valid  <= 1'b1;
`ifdef LIFE_PERIOD2_DETECT_EN
        prev2_q     <= prev_q;
        prev2_valid <= prev_valid;
`endif
      end
    end
  end

endmodule

// File: tb/tb_life_run_ctrl.sv
// Directed bench: behavioural toroidal life engine wired to life_run_ctrl.
module tb_life_run_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort, stop_on_still;
  logic [255:0] pattern;
  logic [15:0]  max_gen;
  logic         busy, done, eng_load;
  logic [1:0]   stop_reason;
  logic [15:0]  gen_count;
  logic [8:0]   pop_count;
  logic [255:0] eng_data;
  logic [255:0] eng_q = '0;

  int checks = 0;
  int errors = 0;

  logic [255:0] blinker_h, blinker_v, block, single, glider;

  always #5 clk = ~clk;

  life_run_ctrl #(.GEN_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .pattern       (pattern),
    .max_gen       (max_gen),
    .stop_on_still (stop_on_still),
    .busy          (busy),
    .done          (done),
    .stop_reason   (stop_reason),
    .gen_count     (gen_count),
    .pop_count     (pop_count),
    .eng_load      (eng_load),
    .eng_data      (eng_data),
    .eng_q         (eng_q)
  );

  function automatic logic [255:0] cellbit(input int r, input int c);
    logic [255:0] v;
    v = '0;
    v[r*16 + c] = 1'b1;
    return v;
  endfunction

  function automatic logic [255:0] life_next(input logic [255:0] g);
    logic [255:0] nx;
    int n;
    nx = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        n = 0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1))
              n += int'(g[((r + dr + 15) % 16)*16 + ((c + dc + 15) % 16)]);
          end
        end
        nx[r*16 + c] = (n == 3) || (g[r*16 + c] && n == 2);
      end
    end
    return nx;
  endfunction

  always @(posedge clk) eng_q <= eng_load ? eng_data : life_next(eng_q);

  task automatic do_start(input logic [255:0] p, input logic [15:0] mg, input logic still);
    @(negedge clk);
    start = 1'b1; pattern = p; max_gen = mg; stop_on_still = still;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles, output bit seen);
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stop_on_still = 1'b0;
    pattern = '0; max_gen = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stop_reason !== 2'd0 || gen_count !== 16'd0 ||
        pop_count !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b reason=%0d gen=%0d pop=%0d, want 0 0 0 0 0",
               busy, done, stop_reason, gen_count, pop_count);
    end
    checks++;
    if (eng_load !== 1'b1 || eng_data !== eng_q) begin
      errors++;
      $display("FAIL reset_engine_hold: eng_load=%b hold=%b, want 1 1", eng_load, eng_data === eng_q);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_blinker_maxgen;
    int cyc; bit seen;
    do_start(blinker_h, 16'd5, 1'b0);
    wait_done(40, cyc, seen);
    checks++;
    if (!seen || cyc != 7) begin
      errors++;
      $display("FAIL blinker_latency: seen=%b cycles=%0d, want 1 7", seen, cyc);
    end
    checks++;
    if (stop_reason !== 2'd0 || gen_count !== 16'd5 || pop_count !== 9'd3) begin
      errors++;
      $display("FAIL blinker_result: reason=%0d gen=%0d pop=%0d, want 0 5 3", stop_reason, gen_count, pop_count);
    end
    checks++;
    if (eng_q !== blinker_v) begin
      errors++;
      $display("FAIL blinker_phase: eng_q=%h, want %h", eng_q, blinker_v);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_maxgen_zero;
    int cyc; bit seen;
    do_start(glider, 16'd0, 1'b0);
    checks++;
    if (eng_load !== 1'b1 || eng_data !== glider || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_phase: eng_load=%b data_ok=%b busy=%b, want 1 1 1", eng_load, eng_data === glider, busy);
    end
    wait_done(10, cyc, seen);
    checks++;
    if (!seen || cyc != 2 || stop_reason !== 2'd0 || gen_count !== 16'd0 || pop_count !== 9'd5) begin
      errors++;
      $display("FAIL maxgen_zero: seen=%b cyc=%0d reason=%0d gen=%0d pop=%0d, want 1 2 0 0 5",
               seen, cyc, stop_reason, gen_count, pop_count);
    end
  endtask

  task automatic test_block_still;
    int cyc; bit seen;
    do_start(block, 16'd100, 1'b1);
    wait_done(20, cyc, seen);
    checks++;
    if (!seen || stop_reason !== 2'd2 || gen_count !== 16'd1 || pop_count !== 9'd4) begin
      errors++;
      $display("FAIL block_still: seen=%b reason=%0d gen=%0d pop=%0d, want 1 2 1 4",
               seen, stop_reason, gen_count, pop_count);
    end
  endtask

  task automatic test_extinct;
    int cyc; bit seen;
    do_start(single, 16'd10, 1'b0);
    wait_done(20, cyc, seen);
    checks++;
    if (!seen || stop_reason !== 2'd1 || gen_count !== 16'd1 || pop_count !== 9'd0) begin
      errors++;
      $display("FAIL extinct_single: seen=%b reason=%0d gen=%0d pop=%0d, want 1 1 1 0",
               seen, stop_reason, gen_count, pop_count);
    end
    do_start('0, 16'd10, 1'b0);
    wait_done(20, cyc, seen);
    checks++;
    if (!seen || cyc != 3 || stop_reason !== 2'd1 || gen_count !== 16'd0 || pop_count !== 9'd0) begin
      errors++;
      $display("FAIL extinct_empty: seen=%b cyc=%0d reason=%0d gen=%0d pop=%0d, want 1 3 1 0 0",
               seen, cyc, stop_reason, gen_count, pop_count);
    end
  endtask

  task automatic test_abort;
    int n; bit pulsed;
    do_start(glider, 16'd50, 1'b0);
    n = 0;
    while (gen_count !== 16'd7 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (gen_count !== 16'd7) begin
      errors++;
      $display("FAIL abort_reach_gen7: gen=%0d, want 7", gen_count);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || gen_count !== 16'd7 || stop_reason !== 2'd1 || eng_load !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: busy=%b gen=%0d reason=%0d eng_load=%b, want 0 7 1 1",
               busy, gen_count, stop_reason, eng_load);
    end
    pulsed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL abort_no_done: activity=%b, want 0", pulsed);
    end
  endtask

  task automatic test_idle_start_abort;
    bit active;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; pattern = glider; max_gen = 16'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    active = (busy !== 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) active = 1'b1;
    end
    checks++;
    if (active || gen_count !== 16'd7) begin
      errors++;
      $display("FAIL idle_start_abort: active=%b gen=%0d, want 0 7", active, gen_count);
    end
  endtask

  task automatic test_period2;
    int cyc; bit seen;
    do_start(blinker_h, 16'd100, 1'b1);
    wait_done(200, cyc, seen);
    checks++;
`ifdef LIFE_PERIOD2_DETECT_EN
    if (!seen || stop_reason !== 2'd3 || gen_count !== 16'd2 || pop_count !== 9'd3) begin
      errors++;
      $display("FAIL period2: seen=%b reason=%0d gen=%0d pop=%0d, want 1 3 2 3",
               seen, stop_reason, gen_count, pop_count);
    end
`else
    if (!seen || stop_reason !== 2'd0 || gen_count !== 16'd100 || pop_count !== 9'd3) begin
      errors++;
      $display("FAIL period2_off: seen=%b reason=%0d gen=%0d pop=%0d, want 1 0 100 3",
               seen, stop_reason, gen_count, pop_count);
    end
`endif
  endtask

  task automatic test_start_busy;
    int cyc; bit seen;
    do_start(blinker_h, 16'd5, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (eng_load !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_free: eng_load=%b busy=%b, want 0 1", eng_load, busy);
    end
    start = 1'b1; pattern = '0; max_gen = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, cyc, seen);
    checks++;
    if (!seen || stop_reason !== 2'd0 || gen_count !== 16'd5 || pop_count !== 9'd3) begin
      errors++;
      $display("FAIL start_while_busy: seen=%b reason=%0d gen=%0d pop=%0d, want 1 0 5 3",
               seen, stop_reason, gen_count, pop_count);
    end
  endtask

  task automatic test_async_reset;
    do_start(glider, 16'd50, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stop_reason !== 2'd0 || gen_count !== 16'd0 ||
        pop_count !== 9'd0 || eng_load !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b reason=%0d gen=%0d pop=%0d eng_load=%b, want 0 0 0 0 0 1",
               busy, done, stop_reason, gen_count, pop_count, eng_load);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    blinker_h = cellbit(8, 7) | cellbit(8, 8) | cellbit(8, 9);
    blinker_v = cellbit(7, 8) | cellbit(8, 8) | cellbit(9, 8);
    block     = cellbit(4, 4) | cellbit(4, 5) | cellbit(5, 4) | cellbit(5, 5);
    single    = cellbit(10, 3);
    glider    = cellbit(0, 1) | cellbit(1, 2) | cellbit(2, 0) | cellbit(2, 1) | cellbit(2, 2);

    test_reset();
    test_blinker_maxgen();
    test_maxgen_zero();
    test_block_still();
    test_extinct();
    test_abort();
    test_idle_start_abort();
    test_period2();
    test_start_busy();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
